fp32_mult_responder: RTL and testbench



---
 rtl/fp32_mult_responder_if.sv | 19 +
 rtl/fp32_mult_responder.sv | 154 +++++++++++++++
 tb/tb_fp32_mult_responder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp32_mult_responder_if.sv
// Handshake bundle between the filter controller (master) and the fp32 multiplier (slave).
// FP32_MULT_FLAGS_EN adds the registered exception flags {invalid, overflow, underflow, inexact}.
interface fp32_mult_responder_if;
    logic [31:0] a;
    logic [31:0] b;
    logic        operation_nd;
    logic        operation_rfd;
    logic [31:0] result;
    logic        rdy;
`ifdef FP32_MULT_FLAGS_EN
    logic [3:0]  flags;

    modport master (output a, b, operation_nd, input operation_rfd, result, rdy, flags);
    modport slave  (input a, b, operation_nd, output operation_rfd, result, rdy, flags);
`else
    modport master (output a, b, operation_nd, input operation_rfd, result, rdy);
    modport slave  (input a, b, operation_nd, output operation_rfd, result, rdy);
`endif
endinterface

// File: rtl/fp32_mult_responder.sv
// Four-cycle IEEE-754 single multiplier (RNE, flush-to-zero) on the nd/rfd/rdy handshake.
// Optional macro FP32_MULT_FLAGS_EN adds the flags output, registered alongside result.
module fp32_mult_responder #(
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic                 clk,
    input  logic                 rst,
    fp32_mult_responder_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_NORM = 2'd2;
    localparam logic [1:0] S_RND  = 2'd3;

    logic [1:0]        r_state;
    logic [31:0]       r_a, r_b;
    logic [47:0]       r_prod;
    logic signed [9:0] r_exp;
    logic              r_sign, r_nan, r_inf, r_zero;
    logic [23:0]       r_mant;
    logic              r_guard, r_sticky;
    logic [31:0]       r_result;
    logic              r_rdy;

    // MUL: operand classification and raw significand product
    logic [7:0]        w_ea, w_eb;
    logic [22:0]       w_fa, w_fb;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [47:0]       w_prod;
    logic signed [9:0] w_exp_sum;

    assign w_ea      = r_a[30:23];
    assign w_eb      = r_b[30:23];
    assign w_fa      = r_a[22:0];
    assign w_fb      = r_b[22:0];
    assign w_a_zero  = (w_ea == 8'h00);
    assign w_b_zero  = (w_eb == 8'h00);
    assign w_a_inf   = (w_ea == 8'hFF) && (w_fa == 23'd0);
    assign w_b_inf   = (w_eb == 8'hFF) && (w_fb == 23'd0);
    assign w_a_nan   = (w_ea == 8'hFF) && (w_fa != 23'd0);
    assign w_b_nan   = (w_eb == 8'hFF) && (w_fb != 23'd0);
    assign w_prod    = 48'({1'b1, w_fa}) * 48'({1'b1, w_fb});
    assign w_exp_sum = {2'b00, w_ea} + {2'b00, w_eb} - 10'd127;

    // NORM: product lies in [1,4); a set bit 47 means one extra binade
    logic [23:0]       w_norm_mant;
    logic              w_norm_guard, w_norm_sticky;
    logic signed [9:0] w_norm_exp;

    assign w_norm_mant   = r_prod[47] ? r_prod[47:24] : r_prod[46:23];
    assign w_norm_guard  = r_prod[47] ? r_prod[23]    : r_prod[22];
    assign w_norm_sticky = r_prod[47] ? |r_prod[22:0] : |r_prod[21:0];
    assign w_norm_exp    = r_exp + {9'd0, r_prod[47]};

    // RND: a carry out of the mantissa leaves 1.000..., so renormalise by one
    logic              w_round_up;
    logic [24:0]       w_mant_rnd;
    logic signed [9:0] w_exp_fin;
    logic [22:0]       w_frac;
    logic              w_ovf, w_unf;
    logic [31:0]       w_result;

    assign w_round_up = r_guard & (r_sticky | r_mant[0]);
    assign w_mant_rnd = {1'b0, r_mant} + 25'(w_round_up);
    assign w_exp_fin  = r_exp + {9'd0, w_mant_rnd[24]};
    assign w_frac     = w_mant_rnd[24] ? w_mant_rnd[23:1] : w_mant_rnd[22:0];
    assign w_ovf      = (w_exp_fin >= 10'sd255);
    assign w_unf      = (w_exp_fin <= 10'sd0);

    always_comb begin
        w_result = {r_sign, w_exp_fin[7:0], w_frac};
        if (r_nan)       w_result = QNAN;
        else if (r_inf)  w_result = {r_sign, 8'hFF, 23'd0};
        else if (r_zero) w_result = {r_sign, 31'd0};
        else if (w_ovf)  w_result = {r_sign, 8'hFF, 23'd0};
        else if (w_unf)  w_result = {r_sign, 31'd0};
    end

    // Control: state, rdy pulse and the held result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_rdy    <= 1'b0;
            r_result <= 32'h0000_0000;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                S_IDLE: if (bus.operation_nd) r_state <= S_MUL;
                S_MUL:  r_state <= S_NORM;
                S_NORM: r_state <= S_RND;
                S_RND: begin
                    r_result <= w_result;
                    r_rdy    <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef FP32_MULT_FLAGS_EN
    logic       r_denorm;
    logic [3:0] r_flags, w_flags;

    always_comb begin
        w_flags = {3'b000, r_guard | r_sticky};
        if (r_nan)       w_flags = 4'b1000;
        else if (r_inf)  w_flags = 4'b0000;
        else if (r_zero) w_flags = {2'b00, r_denorm, r_denorm};
        else if (w_ovf)  w_flags = 4'b0101;
        else if (w_unf)  w_flags = 4'b0011;
    end

    always_ff @(posedge clk) begin
        if (rst)                    r_flags <= 4'b0000;
        else if (r_state == S_RND)  r_flags <= w_flags;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_MUL) r_denorm <= (w_a_zero && w_fa != 23'd0) || (w_b_zero && w_fb != 23'd0);
    end

    assign bus.flags = r_flags;
`endif

    // NOTE: pure datapath registers carry no reset; the control path alone decides when they matter.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (bus.operation_nd) begin
                r_a <= bus.a;
                r_b <= bus.b;
            end
            S_MUL: begin
                r_prod <= w_prod;
                r_exp  <= w_exp_sum;
                r_sign <= r_a[31] ^ r_b[31];
                r_nan  <= w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero);
                r_inf  <= w_a_inf | w_b_inf;
                r_zero <= w_a_zero | w_b_zero;
            end
            S_NORM: begin
                r_mant   <= w_norm_mant;
                r_guard  <= w_norm_guard;
                r_sticky <= w_norm_sticky;
                r_exp    <= w_norm_exp;
            end
            default: ;
        endcase
    end

    assign bus.operation_rfd = (r_state == S_IDLE);
    assign bus.result        = r_result;
    assign bus.rdy           = r_rdy;
endmodule

// File: tb/tb_fp32_mult_responder.sv
// Randomised bench for fp32_mult_responder against an integer-arithmetic float model.
// Build with FP32_MULT_FLAGS_EN defined to also check the flags output.
module tb_fp32_mult_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    fp32_mult_responder_if bus ();

    fp32_mult_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Exact product of the significands, rounded half-to-even by integer remainder.
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        logic              s;
        int                ex, ey, e, k, drop;
        longint unsigned   p, q, rem, half;
        bit                nx, ny, ix, iy, zx, zy, den, up;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        nx = (ex == 255) && (x[22:0] != 0);
        ny = (ey == 255) && (y[22:0] != 0);
        ix = (ex == 255) && (x[22:0] == 0);
        iy = (ey == 255) && (y[22:0] == 0);
        zx = (ex == 0);
        zy = (ey == 0);
        if (nx || ny || (ix && zy) || (iy && zx)) return {4'b1000, 32'h7FC00000};
        if (ix || iy) return {4'b0000, s, 8'hFF, 23'd0};
        if (zx || zy) begin
            den = (zx && x[22:0] != 0) || (zy && y[22:0] != 0);
            return {2'b00, den, den, s, 31'd0};
        end
        p = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
        k = (p >= (64'd1 << 47)) ? 47 : 46;
        drop = k - 23;
        q    = p >> drop;
        rem  = p - (q << drop);
        half = 64'd1 << (drop - 1);
        up   = (rem > half) || (rem == half && q[0]);
        q    = q + longint'(up);
        e    = ex + ey - 127 + (k - 46);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0)   return {4'b0011, s, 31'd0};
        return {3'b000, rem != 0, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 11))
            0:  v[30:0] = 31'd0;
            1:  v[30:23] = 8'h00;
            2:  v[30:0] = {8'hFF, 23'd0};
            3:  v[30:23] = 8'hFF;
            4:  v[30:23] = 8'($urandom_range(190, 254));
            5:  v[30:23] = 8'($urandom_range(1, 64));
            6:  v[22:0] = 23'h7FFFFF;
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Cycle-level reference: countdown of busy cycles plus the expected held outputs.
    int          m_left   = 0;
    bit          m_valid  = 0;
    logic        m_rdy    = 1'b0;
    logic [31:0] m_result = 32'd0;
    logic [3:0]  m_flags  = 4'd0;
    logic [35:0] m_pending;

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            check("rfd", 32'(bus.operation_rfd), 32'(m_left == 0));
            check("rdy", 32'(bus.rdy), 32'(m_rdy));
            check("result", bus.result, m_result);
`ifdef FP32_MULT_FLAGS_EN
            check("flags", 32'(bus.flags), 32'(m_flags));
`endif
        end
        if (rst) begin
            m_left = 0; m_rdy = 1'b0; m_result = 32'd0; m_flags = 4'd0; m_valid = 1;
        end else if (m_valid) begin
            m_rdy = 1'b0;
            if (m_left == 1) begin
                m_rdy = 1'b1;
                {m_flags, m_result} = m_pending;
                m_left = 0;
            end else if (m_left > 1) begin
                m_left--;
            end else if (bus.operation_nd) begin
                m_pending = model(bus.a, bus.b);
                m_left = 3;
            end
        end
    end

    logic [31:0] tv_a [11] = '{32'h3FC00000, 32'hBF99999A, 32'h3F800001, 32'h7F000000, 32'h00800000,
                               32'h80800000, 32'h7F800000, 32'h7FC12345, 32'hFF800000, 32'h00000001,
                               32'h3FFFFFFF};
    logic [31:0] tv_b [11] = '{32'h40000000, 32'h40400000, 32'h3F800001, 32'h40000000, 32'h3F000000,
                               32'h3F000000, 32'h00000000, 32'h3F800000, 32'h40000000, 32'h7F000000,
                               32'h3FFFFFFF};
    logic [31:0] tv_r [11] = '{32'h40400000, 32'hC0666667, 32'h3F800002, 32'h7F800000, 32'h00000000,
                               32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h00000000,
                               32'h407FFFFE};

    task automatic do_op(input logic [31:0] xa, input logic [31:0] xb, input logic [31:0] want);
        int n, low;
        @(posedge clk); #1;
        bus.a = xa; bus.b = xb; bus.operation_nd = 1'b1;
        @(posedge clk); #1;
        bus.operation_nd = 1'b0; bus.a = $urandom; bus.b = $urandom;
        n = 1; low = 0;
        while (!bus.rdy && n < 20) begin
            if (!bus.operation_rfd) low++;
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'd4);
        check("rfd_low_cycles", 32'(low), 32'd3);
        check("op_result", bus.result, want);
    endtask

    initial begin
        logic [31:0] ha [6];
        logic [31:0] hb [6];
        logic [31:0] hres [2];
        int          hcyc [2];
        int          pulses;
        logic [35:0] mv;

        bus.a = 32'd0; bus.b = 32'd0; bus.operation_nd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rfd", 32'(bus.operation_rfd), 32'd1);
        check("reset_rdy", 32'(bus.rdy), 32'd0);
        check("reset_result", bus.result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            mv = model(tv_a[i], tv_b[i]);
            check("model_pin", mv[31:0], tv_r[i]);
        end
        mv = model(32'h7F000000, 32'h40000000);
        check("model_ovf_flags", 32'(mv[35:32]), 32'h5);
        mv = model(32'h00800000, 32'h3F000000);
        check("model_unf_flags", 32'(mv[35:32]), 32'h3);
        mv = model(32'h7F800000, 32'h00000000);
        check("model_inv_flags", 32'(mv[35:32]), 32'h8);

        for (int i = 0; i < 11; i++) do_op(tv_a[i], tv_b[i], tv_r[i]);

        // nd held for six cycles: only cycle 0 and cycle 4 operands are taken
        for (int i = 0; i < 6; i++) begin
            ha[i] = rand_fp();
            hb[i] = rand_fp();
        end
        pulses = 0;
        @(posedge clk); #1;
        for (int k = 0; k < 14; k++) begin
            if (k < 6) begin
                bus.a = ha[k]; bus.b = hb[k]; bus.operation_nd = 1'b1;
            end else begin
                bus.operation_nd = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.rdy) begin
                if (pulses < 2) begin
                    hres[pulses] = bus.result;
                    hcyc[pulses] = k + 1;
                end
                pulses++;
            end
        end
        check("hold_pulses", 32'(pulses), 32'd2);
        mv = model(ha[0], hb[0]);
        check("hold_first", hres[0], mv[31:0]);
        mv = model(ha[4], hb[4]);
        check("hold_second", hres[1], mv[31:0]);
        check("hold_first_cycle", 32'(hcyc[0]), 32'd4);
        check("hold_second_cycle", 32'(hcyc[1]), 32'd8);

        // reset while the operation sits in NORM
        @(posedge clk); #1;
        bus.a = 32'h40400000; bus.b = 32'h40400000; bus.operation_nd = 1'b1;
        @(posedge clk); #1;
        bus.operation_nd = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rdy", 32'(bus.rdy), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_rfd", 32'(bus.operation_rfd), 32'd1);
        pulses = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.rdy) pulses++;
        end
        check("abort_no_rdy", 32'(pulses), 32'd0);
        do_op(32'h3FC00000, 32'h40000000, 32'h40400000);

        // random traffic, checked every cycle by the reference process
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.a = rand_fp();
            bus.b = rand_fp();
            bus.operation_nd = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        bus.operation_nd = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
